// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with carry in/out and optional registered output
//
// Ports:
//   clk        in   1      clock, rising-edge active (used only in registered mode)
//   rst_n      in   1      asynchronous active-low reset (used only in registered mode)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   carry_in   in   1      carry into bit 0
//   in_valid   in   1      operands valid this cycle
//   sum        out  WIDTH  sum bits, a + b + carry_in modulo 2^WIDTH
//   carry_out  out  1      carry out of bit WIDTH-1
//   out_valid  out  1      sum/carry_out valid
//
// Configuration macro FULL_ADDER_REG_OUT_EN:
//   defined   -> outputs registered, one cycle of latency, asynchronous reset clears them
//   undefined -> outputs purely combinational, clk and rst_n unused
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             out_valid
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   assign c[0] = carry_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

`ifdef FULL_ADDER_REG_OUT_EN
   // Results hold while in_valid is low so a stalled consumer keeps the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         carry_out <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum       <= s;
            carry_out <= c[WIDTH];
         end
      end
   end
`else
   // clk and rst_n stay on the port list so both builds share one interface.
   logic unused;
   assign unused    = clk ^ rst_n;
   assign sum       = s;
   assign carry_out = c[WIDTH];
   assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for full_adder at WIDTH=1 and WIDTH=8, either output mode
module tb_full_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a1, b1, c1, iv1, s1, co1, ov1;
   logic [7:0] a8, b8, s8;
   logic       c8, iv8, co8, ov8;
   logic       mon_en = 1'b0;
   int         checks = 0;
   int         fails = 0;
   logic [1:0] q1[$];
   logic [8:0] q8[$];

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry_in(c1), .in_valid(iv1),
      .sum(s1), .carry_out(co1), .out_valid(ov1)
   );

   full_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry_in(c8), .in_valid(iv8),
      .sum(s8), .carry_out(co8), .out_valid(ov8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer addition, truncated to WIDTH+1 bits.
   task automatic drive(input logic [2:0] v1, input logic va, input logic [7:0] xa,
                        input logic [7:0] xb, input logic xc, input logic vb);
      int r1, r8;
      {a1, b1, c1} = v1;
      iv1 = va;
      a8 = xa; b8 = xb; c8 = xc;
      iv8 = vb;
      r1 = int'(v1[2]) + int'(v1[1]) + int'(v1[0]);
      r8 = int'(xa) + int'(xb) + int'(xc);
      if (va) q1.push_back(r1[1:0]);
      if (vb) q8.push_back(r8[8:0]);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en && ov1 === 1'b1) begin
         if (q1.size() == 0) check("w1 unexpected out_valid", 32'(ov1), 32'd0);
         else check("w1 {carry_out,sum}", 32'({co1, s1}), 32'(q1.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (mon_en && ov8 === 1'b1) begin
         if (q8.size() == 0) check("w8 unexpected out_valid", 32'(ov8), 32'd0);
         else check("w8 {carry_out,sum}", 32'({co8, s8}), 32'(q8.pop_front()));
      end
   end

   logic [2:0] dir1[12] = '{3'b001, 3'b011, 3'b111, 3'b000,
                            3'b000, 3'b001, 3'b010, 3'b011,
                            3'b100, 3'b101, 3'b110, 3'b111};
   logic [16:0] dir8[4] = '{{8'hFF, 8'h01, 1'b0}, {8'hFF, 8'hFF, 1'b1},
                            {8'h00, 8'h00, 1'b0}, {8'h00, 8'h00, 1'b1}};

   initial begin
      rst_n = 1'b0;
      {a1, b1, c1, iv1} = '0;
      {a8, b8, c8, iv8} = '0;
      #1;
      check("w1 reset state", 32'({ov1, co1, s1}), 32'd0);
      check("w8 reset state", 32'({ov8, co8, s8}), 32'd0);
      @(posedge clk);
      #1;
      check("w1 reset held over clk", 32'({ov1, co1, s1}), 32'd0);
      check("w8 reset held over clk", 32'({ov8, co8, s8}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i < 4) drive(dir1[i], 1'b1, dir8[i][16:9], dir8[i][8:1], dir8[i][0], 1'b1);
         else drive(dir1[i], 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      end
      for (int i = 0; i < 300; i++)
         drive(3'($urandom), $urandom_range(3) != 0, 8'($urandom), 8'($urandom),
               1'($urandom), $urandom_range(3) != 0);
      {iv1, iv8} = 2'b00;
      for (int i = 0; i < 10 && (q1.size() != 0 || q8.size() != 0); i++) @(posedge clk);
      @(negedge clk);
      #1;
      check("w1 scoreboard drained", 32'(q1.size()), 32'd0);
      check("w8 scoreboard drained", 32'(q8.size()), 32'd0);
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      // Load one result, then hit reset mid-cycle before the next edge.
      {a1, b1, c1, iv1} = 4'b1111;
      {a8, b8, c8, iv8} = {8'hFF, 8'hFF, 2'b11};
      @(posedge clk);
      #1;
      {iv1, iv8} = 2'b00;
`ifdef FULL_ADDER_REG_OUT_EN
      check("w1 loaded before reset", 32'({ov1, co1, s1}), 32'h7);
      check("w8 loaded before reset", 32'({ov8, co8, s8}), 32'h3FF);
`else
      check("w1 loaded before reset", 32'({ov1, co1, s1}), 32'h3);
      check("w8 loaded before reset", 32'({ov8, co8, s8}), 32'h1FF);
`endif
      #2;
      rst_n = 1'b0;
      #1;
`ifdef FULL_ADDER_REG_OUT_EN
      check("w1 async reset mid-cycle", 32'({ov1, co1, s1}), 32'h0);
      check("w8 async reset mid-cycle", 32'({ov8, co8, s8}), 32'h0);
`else
      check("w1 reset no effect", 32'({ov1, co1, s1}), 32'h3);
      check("w8 reset no effect", 32'({ov8, co8, s8}), 32'h1FF);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
`ifdef FULL_ADDER_REG_OUT_EN
      check("w1 hold zero after release", 32'({ov1, co1, s1}), 32'h0);
      check("w8 hold zero after release", 32'({ov8, co8, s8}), 32'h0);
`else
      check("w1 after release", 32'({ov1, co1, s1}), 32'h3);
      check("w8 after release", 32'({ov8, co8, s8}), 32'h1FF);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
